pwm_sample_decoder: RTL and testbench
=====================================

// Module: pwm_sample_decoder
// PURPOSE
//  Receive side of the audio PWM link: recovers the N-bit sample that the PWM encoder
//  expresses as a duty cycle. Aligns to frame starts, counts high cycles in each
//  2^SAMPLE_W-clock frame and presents one sample per frame on a valid/ready interface.
//  Sits on a loopback of AUD_PWM (or an external PWM pin) and feeds capture/compare logic.
// PARAMETERS
//  SAMPLE_W   11  sample width; frame length is 2^SAMPLE_W clocks (2048 at default)
//  ALIGN_TOL   2  max |offset| in clocks between a rising edge and the frame boundary
//  MAX_ERR     3  consecutive misaligned frames before dropping back to HUNT
// PORTS
//  CLK100MHZ     in   1         system clock, all logic on rising edge
//  CPU_RESETN    in   1         asynchronous active-low reset
//  pwm_in        in   1         asynchronous PWM bitstream
//  sample_data   out  SAMPLE_W  recovered sample (number of high clocks in the frame)
//  sample_valid  out  1         sample_data holds an unconsumed sample
//  sample_ready  in   1         consumer accepts sample_data when valid && ready
//  sample_err    out  1         the frame that produced sample_data had a misaligned edge
//  overrun       out  1         1-cycle pulse: an unconsumed sample was overwritten
//  locked        out  1         1 in LOCKED state
// BEHAVIOUR
//  Reset: sample_data=0, sample_valid=0, sample_err=0, overrun=0, locked=0, state=HUNT,
//   sync flops=0, frame_cnt=0, high_cnt=0, err_cnt=0. Reset may assert at any cycle;
//   a partially counted frame is discarded, with no sample emitted.
//  Input: pwm_in goes through a 2-flop synchroniser; s = 2nd stage; rise = s && !s_d.
//  FSM HUNT: counters held at 0. On rise -> LOCKED, frame_cnt=1, high_cnt=1 (the rising
//   cycle is the first clock of the frame).
//  FSM LOCKED: frame_cnt increments each clock and wraps 2^SAMPLE_W-1 -> 0.
//   high_cnt += s. frame_cnt==0 is the first clock of a frame.
//  Frame end (clock where frame_cnt==2^SAMPLE_W-1): next cycle sample_data = final
//   high_cnt (includes the last clock), sample_valid=1, sample_err = frame_err;
//   high_cnt restarts with the new frame's first clock; frame_err is cleared.
//  high_cnt width SAMPLE_W; max count is 2^SAMPLE_W-1 because the encoder always emits
//   >=1 low clock. All 2^SAMPLE_W high: saturate at 2^SAMPLE_W-1 and set sample_err.
//  Alignment: a rise in LOCKED with frame_cnt not in [0..ALIGN_TOL] and not in
//   [2^SAMPLE_W-ALIGN_TOL..2^SAMPLE_W-1] sets frame_err. No rise in a frame is legal
//   (sample 0).
//  err_cnt: at each frame end, +1 if frame_err, else cleared. When it reaches MAX_ERR ->
//   HUNT, err_cnt=0, locked=0. That errored sample is still emitted.
//  Handshake: transfer when valid && ready. Valid stays high, data stable, until transfer.
//   New sample with valid=1 and no transfer that cycle: overwrite data/err, valid stays 1,
//   overrun=1 for 1 cycle. New sample in the same cycle as a transfer: load new sample,
//   valid stays 1, no overrun.
//  Latency: pwm_in edge -> s: 2 clocks. Last frame clock -> sample_valid: 1 clock.
// TESTING
//  1. Reset, then an ideal encoder stream of 2048-clock frames with value 1024 ->
//     locked=1 after the first rise; every frame yields sample_data=1024, sample_err=0.
//  2. Values 0, 1 and 2047 in consecutive frames with ready=1 -> samples 0, 1, 2047, all
//     with sample_err=0; lock held through the value-0 frame.
//  3. ready=0 for 3 frames -> first sample held until overwritten; 2 overrun pulses;
//     after ready=1, the latest sample transfers exactly once.
//  4. Encoder phase jumped by 500 clocks for 3 frames -> sample_err=1 on each;
//     locked=0 after the 3rd frame end; re-lock on the next rise, then clean samples.
//  5. Edge jitter +/-2 clocks on value 700 -> sample_err=0; samples within 700+/-2.
//  6. CPU_RESETN low mid-frame -> all outputs 0 asynchronously; after release no sample
//     until a full frame following the next rise.

Source files
------------

// File: rtl/pwm_sample_decoder.sv
// PWM duty-cycle receiver: aligns to frame starts and recovers one
// SAMPLE_W-bit sample per 2^SAMPLE_W-clock frame on a valid/ready port.
// Ports:
//   CLK100MHZ    system clock (rising edge)
//   CPU_RESETN   asynchronous active-low reset
//   pwm_in       asynchronous PWM bitstream
//   sample_data  recovered sample (high clocks in the frame)
//   sample_valid sample_data holds an unconsumed sample
//   sample_ready consumer accepts when valid && ready
//   sample_err   frame behind sample_data was misaligned or saturated
//   overrun      1-cycle pulse: unconsumed sample overwritten
//   locked       high while in LOCKED
module pwm_sample_decoder #(
   parameter int SAMPLE_W  = 11,
   parameter int ALIGN_TOL = 2,
   parameter int MAX_ERR   = 3
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic                pwm_in,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                sample_err,
   output logic                overrun,
   output logic                locked
);

   localparam int EW = $clog2(MAX_ERR + 1);
   localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;
   localparam logic [SAMPLE_W-1:0] TOL     = SAMPLE_W'(ALIGN_TOL);
   localparam logic [EW-1:0]       ERR_LIM = EW'(MAX_ERR);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t              state;
   logic                sync1, s, s_d;
   logic [SAMPLE_W-1:0] frame_cnt;
   logic [SAMPLE_W-1:0] high_cnt;
   logic                frame_err;
   logic [EW-1:0]       err_cnt;

   logic                rise;
   logic                in_window;
   logic                sat;
   logic [SAMPLE_W-1:0] high_nxt;
   logic                err_nxt;
   logic                frame_end;
   logic [EW-1:0]       err_inc;

   always_comb begin
      rise      = s && !s_d;
      // Edges are tolerated within TOL clocks either side of the boundary.
      in_window = (frame_cnt <= TOL) || (frame_cnt > (CNT_MAX - TOL));
      // A fully-high frame cannot be represented; clamp and flag it.
      sat       = s && (high_cnt == CNT_MAX);
      high_nxt  = sat ? CNT_MAX
                      : high_cnt + {{(SAMPLE_W-1){1'b0}}, s};
      err_nxt   = frame_err || sat || (rise && !in_window);
      frame_end = (state == LOCKED) && (frame_cnt == CNT_MAX);
      err_inc   = err_cnt + EW'(1);
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state        <= HUNT;
         sync1        <= 1'b0;
         s            <= 1'b0;
         s_d          <= 1'b0;
         frame_cnt    <= '0;
         high_cnt     <= '0;
         frame_err    <= 1'b0;
         err_cnt      <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         sample_err   <= 1'b0;
         overrun      <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sync1   <= pwm_in;
         s       <= sync1;
         s_d     <= s;
         overrun <= 1'b0;

         if (sample_valid && sample_ready)
            sample_valid <= 1'b0;

         unique case (state)
            HUNT: begin
               frame_cnt <= '0;
               high_cnt  <= '0;
               frame_err <= 1'b0;
               err_cnt   <= '0;
               locked    <= 1'b0;
               // The rising clock itself is position 0 of the frame.
               if (rise) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  frame_cnt <= SAMPLE_W'(1);
                  high_cnt  <= SAMPLE_W'(1);
               end
            end

            LOCKED: begin
               frame_cnt <= frame_cnt + SAMPLE_W'(1);
               if (frame_end) begin
                  sample_data  <= high_nxt;
                  sample_err   <= err_nxt;
                  sample_valid <= 1'b1;
                  overrun      <= sample_valid && !sample_ready;
                  high_cnt     <= '0;
                  frame_err    <= 1'b0;
                  if (err_nxt) begin
                     if (err_inc == ERR_LIM) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        err_cnt   <= '0;
                        frame_cnt <= '0;
                     end else begin
                        err_cnt <= err_inc;
                     end
                  end else begin
                     err_cnt <= '0;
                  end
               end else begin
                  high_cnt  <= high_nxt;
                  frame_err <= err_nxt;
               end
            end

            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed bench for pwm_sample_decoder: drives encoder-style frames and
// checks each transferred sample against a queue of expected values.
module tb_pwm_sample_decoder;

   localparam int FL = 2048;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pwm_in;
   logic [10:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic        sample_err;
   logic        overrun;
   logic        locked;

   int vectors     = 0;
   int miscompares = 0;
   int n_xfer      = 0;
   int ovr_cnt     = 0;
   int exp_q[$];

   pwm_sample_decoder dut (
      .CLK100MHZ   (clk),
      .CPU_RESETN  (rst_n),
      .pwm_in      (pwm_in),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .sample_err  (sample_err),
      .overrun     (overrun),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic fbit(int val, int r, int f, int rn, int p);
      int lo;
      lo = (r > 0) ? r : 0;
      return ((p >= lo) && (p < val + f)) || ((rn < 0) && (p >= FL + rn));
   endfunction

   task automatic drive_clk(input logic b);
      pwm_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic run_part(input int val, r, f, rn, from, to);
      for (int p = from; p < to; p++)
         drive_clk(fbit(val, r, f, rn, p));
   endtask

   task automatic run_frame(input int val);
      run_part(val, 0, 0, 0, 0, FL);
   endtask

   task automatic push(input int val, input int err);
      exp_q.push_back((val << 1) | err);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (overrun) ovr_cnt++;
         if (sample_valid && sample_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               check("unexpected_sample", 32'(sample_data), 32'hFFFF);
            end else begin
               int e;
               e = exp_q.pop_front();
               check("sample_data", 32'(sample_data), 32'(e >> 1));
               check("sample_err", 32'(sample_err), 32'(e & 1));
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int jr[7];
      int jf[6];
      int jexp[6];
      jr   = '{0, 1, -1, 2, -2, 0, 0};
      jf   = '{1, -1, 1, 2, -2, 0};
      jexp = '{701, 699, 701, 702, 698, 700};

      pwm_in       = 1'b0;
      sample_ready = 1'b1;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", 32'(sample_data), 0);
      check("rst_valid", 32'(sample_valid), 0);
      check("rst_err", 32'(sample_err), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_locked", 32'(locked), 0);
      rst_n = 1'b1;
      repeat (4) drive_clk(1'b0);
      check("hunt_locked", 32'(locked), 0);

      // ideal 1024 stream
      repeat (3) push(1024, 0);
      run_frame(1024);
      check("lock_after_rise", 32'(locked), 1);
      run_frame(1024);
      run_frame(1024);

      // boundary values
      push(0, 0); push(1, 0); push(2047, 0);
      run_frame(0);
      check("lock_thru_zero", 32'(locked), 1);
      run_frame(1);
      run_frame(2047);
      check("lock_after_2047", 32'(locked), 1);

      // backpressure: 100 and 200 get overwritten
      push(300, 0); push(400, 0);
      run_part(100, 0, 0, 0, 0, 10);
      sample_ready = 1'b0;
      run_part(100, 0, 0, 0, 10, FL);
      run_frame(200);
      check("hold_data_100", 32'(sample_data), 100);
      check("hold_valid", 32'(sample_valid), 1);
      run_frame(300);
      check("hold_data_200", 32'(sample_data), 200);
      run_part(400, 0, 0, 0, 0, 10);
      check("hold_data_300", 32'(sample_data), 300);
      check("hold_valid_300", 32'(sample_valid), 1);
      check("overrun_pulses", 32'(ovr_cnt), 2);
      sample_ready = 1'b1;
      run_part(400, 0, 0, 0, 10, FL);

      // phase jump of 500 clocks
      repeat (3) push(1024, 1);
      repeat (2) push(1024, 0);
      repeat (500) drive_clk(1'b0);
      run_frame(1024);
      run_frame(1024);
      check("locked_mid_err", 32'(locked), 1);
      run_frame(1024);
      check("unlock_after_3", 32'(locked), 0);
      run_frame(1024);
      check("relock", 32'(locked), 1);
      run_frame(1024);

      // edge jitter around 700
      for (int k = 0; k < 6; k++) push(jexp[k], 0);
      for (int k = 0; k < 6; k++)
         run_part(700, jr[k], jf[k], jr[k+1], 0, FL);
      check("jitter_locked", 32'(locked), 1);

      // asynchronous reset mid-frame
      run_part(1024, 0, 0, 0, 0, 1500);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_data", 32'(sample_data), 0);
      check("arst_valid", 32'(sample_valid), 0);
      check("arst_err", 32'(sample_err), 0);
      check("arst_overrun", 32'(overrun), 0);
      check("arst_locked", 32'(locked), 0);
      repeat (3) drive_clk(1'b0);
      rst_n = 1'b1;
      run_part(1024, 0, 0, 0, 1500, FL);
      check("post_rst_valid", 32'(sample_valid), 0);
      check("post_rst_locked", 32'(locked), 0);
      repeat (2) push(1024, 0);
      run_frame(1024);
      run_frame(1024);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++)
         drive_clk(1'b0);
      check("queue_drained", 32'(exp_q.size()), 0);
      check("transfer_count", 32'(n_xfer), 21);
      check("overrun_total", 32'(ovr_cnt), 2);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
